// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the legality/alignment check applied at request accept.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // 1 when the request has a legal funct3 and a naturally aligned address.
  function automatic logic req_ok(input logic we, input logic [2:0] f3,
                                  input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = ~a[0];
        F3_W:    ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: ok = 1'b1;
        F3_H, F3_HU: ok = ~a[0];
        F3_W:        ok = (a == 2'b00);
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the byte/halfword addressed within the word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed lane, then extend according to funct3.
  always_comb begin
    case (addr)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      F3_W:    data = rdata;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, alignment check at accept,
// read-modify-write for sub-word stores, valid/ready response to writeback.
module lsu
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd,
  output logic        o_rsp_is_load,
  output logic        o_rsp_err
);

  lsu_state_t  state;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [4:0]  cap_rd;
  logic [31:0] merged;
  logic [31:0] merge_word;
  logic [31:0] load_val;

  lsu_load_align u_align (
    .rdata  (i_mem_rdata),
    .addr   (cap_addr[1:0]),
    .funct3 (cap_f3),
    .data   (load_val)
  );

  // Replace the addressed byte/halfword of the current memory word with store data.
  always_comb begin
    merge_word = i_mem_rdata;
    if (cap_f3 == F3_B) begin
      case (cap_addr[1:0])
        2'd0:    merge_word[7:0]   = cap_wdata[7:0];
        2'd1:    merge_word[15:8]  = cap_wdata[7:0];
        2'd2:    merge_word[23:16] = cap_wdata[7:0];
        default: merge_word[31:24] = cap_wdata[7:0];
      endcase
    end else if (cap_addr[1]) begin
      merge_word[31:16] = cap_wdata[15:0];
    end else begin
      merge_word[15:0] = cap_wdata[15:0];
    end
  end

  // Memory-side outputs; write enable is gated by reset so a reset during
  // ACCESS/WRITE can never commit a write.
  always_comb begin
    o_mem_addr  = cap_addr;
    o_mem_we    = 1'b0;
    o_mem_wdata = 32'd0;
    if (state == ACCESS) begin
      o_mem_wdata = cap_wdata;
      o_mem_we    = cap_we && (cap_f3 == F3_W);
    end else if (state == WRITE) begin
      o_mem_wdata = merged;
      o_mem_we    = 1'b1;
    end
    if (i_rst) o_mem_we = 1'b0;
  end

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);

  // Request FSM with registered response fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cap_we        <= 1'b0;
      cap_f3        <= 3'd0;
      cap_addr      <= 32'd0;
      cap_wdata     <= 32'd0;
      cap_rd        <= 5'd0;
      merged        <= 32'd0;
      o_rsp_data    <= 32'd0;
      o_rsp_rd      <= 5'd0;
      o_rsp_is_load <= 1'b0;
      o_rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_req_valid) begin
          cap_we    <= i_req_we;
          cap_f3    <= i_req_funct3;
          cap_addr  <= i_req_addr;
          cap_wdata <= i_req_wdata;
          cap_rd    <= i_req_rd;
          if (req_ok(i_req_we, i_req_funct3, i_req_addr[1:0])) begin
            state <= ACCESS;
          end else begin
            state         <= RESP;
            o_rsp_err     <= 1'b1;
            o_rsp_data    <= 32'd0;
            o_rsp_rd      <= i_req_we ? 5'd0 : i_req_rd;
            o_rsp_is_load <= ~i_req_we;
          end
        end
        ACCESS: begin
          if (!cap_we) begin
            o_rsp_data    <= load_val;
            o_rsp_rd      <= cap_rd;
            o_rsp_is_load <= 1'b1;
            o_rsp_err     <= 1'b0;
            state         <= RESP;
          end else if (cap_f3 == F3_W) begin
            o_rsp_data    <= 32'd0;
            o_rsp_rd      <= 5'd0;
            o_rsp_is_load <= 1'b0;
            o_rsp_err     <= 1'b0;
            state         <= RESP;
          end else begin
            merged <= merge_word;
            state  <= WRITE;
          end
        end
        WRITE: begin
          o_rsp_data    <= 32'd0;
          o_rsp_rd      <= 5'd0;
          o_rsp_is_load <= 1'b0;
          o_rsp_err     <= 1'b0;
          state         <= RESP;
        end
        default: if (i_rsp_ready) begin
          o_rsp_data    <= 32'd0;
          o_rsp_rd      <= 5'd0;
          o_rsp_is_load <= 1'b0;
          o_rsp_err     <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the word-wide data memory of the RISC-V core. It accepts one load or store request at a time from execute and checks its alignment. Loads get byte/halfword lane extraction with sign or zero extension. Byte and halfword stores use read-modify-write, because the data memory only writes whole words. Results go to writeback over a valid/ready response handshake.

## Interface
- No parameters; address and data width fixed at 32, register index at 5.
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  execute offers a request
- o_req_ready  out  1  LSU can accept; high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data (low byte/half used for SB/SH)
- i_req_rd  in  5  load destination register
- o_mem_we  out  1  data memory write enable
- o_mem_addr  out  32  data memory byte address (memory indexes by bits [9:2])
- o_mem_wdata  out  32  data memory write word
- i_mem_rdata  in  32  data memory read word, combinational from o_mem_addr
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  writeback accepts response
- o_rsp_data  out  32  extended load data; 0 for stores and errors
- o_rsp_rd  out  5  captured rd; 0 for stores
- o_rsp_is_load  out  1  response belongs to a load
- o_rsp_err  out  1  misaligned access or illegal funct3

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - Request is accepted when i_req_valid && o_req_ready.
  - On accept, capture we/funct3/addr/wdata/rd.
  - Legal and aligned: go to ACCESS.
  - Otherwise go straight to RESP with o_rsp_err = 1.
- Misaligned cases:
  - LH, LHU or SH with addr[0] = 1.
  - LW or SW with addr[1:0] != 0.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any funct3 > 010.
- ACCESS: o_mem_addr = captured addr.
  - Load: extract the lane and register data into the response; go to RESP.
  - SW: o_mem_we = 1 with o_mem_wdata = wdata; go to RESP.
  - SB/SH: register merged word = i_mem_rdata with the addressed lane replaced; go to WRITE.
  - SB lane is addr[1:0]. SH lane is addr[1] (halfword).
- WRITE: o_mem_we = 1, o_mem_wdata = merged word, same address; go to RESP.
- RESP: o_rsp_valid = 1 and response fields are held stable until i_rsp_ready. Then return to IDLE.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the lane.
  - LBU/LHU zero-fill.
  - LW passes the word through.
- o_mem_we is 0 in every other state and is forced to 0 whenever i_rst = 1.
- o_mem_addr holds the last captured address outside ACCESS/WRITE.
- Errored requests never assert o_mem_we.

## Timing
- Accept at edge T. Response valid from cycle:
  - T+1 for errors.
  - T+2 for loads and SW.
  - T+3 for SB/SH.
- Response stays valid through any number of i_rsp_ready = 0 cycles.
- o_req_ready = 0 from T+1 until the cycle after the response handshake. No overlap: at most one request in flight.
- Store write commits at the memory's rising edge ending ACCESS (SW) or WRITE (SB/SH). Exactly one write per store.
- Reset values:
  - State IDLE; o_req_ready = 1 (combinational from IDLE).
  - o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0.
  - o_rsp_valid = 0, o_rsp_data = 0, o_rsp_rd = 0, o_rsp_is_load = 0, o_rsp_err = 0.
- Reset in any state returns to IDLE at the next edge. The in-flight request is dropped and no response is issued.
- Reset asserted during WRITE or ACCESS suppresses that cycle's write.

## Structure
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum (IDLE, ACCESS, WRITE, RESP).
  - An alignment-check function.
- One combinational sub-module, lsu_load_align, takes rdata, addr[1:0] and funct3 and returns the extended load value. The lane-merge for SB/SH stays inline in lsu.

## Test plan
- Memory word 0x10 = 0x8899AABB:
  - LB 0x11 -> 0xFFFFFFAA.
  - LBU 0x11 -> 0x000000AA.
  - LH 0x12 -> 0xFFFF8899.
  - LW 0x10 -> 0x8899AABB.
  - Each load has o_rsp_valid at T+2, rd echoed, o_rsp_err = 0.
- SB 0x13 wdata 0x00000055 on word 0x8899AABB:
  - o_mem_we low in ACCESS, high once in WRITE.
  - Word becomes 0x5599AABB.
  - Response at T+3 with is_load = 0, data = 0.
- SH 0x12 wdata 0x1234 -> word 0x1234AABB. SW 0x14 0xDEADBEEF -> single write at end of ACCESS.
- LW 0x12 and SH 0x11:
  - o_rsp_err = 1 at T+1.
  - o_mem_we never asserted; memory unchanged.
- Response backpressure: hold i_rsp_ready = 0 for 5 cycles after a load.
  - Response stays stable and o_req_ready stays 0.
  - Next request is accepted only after the handshake.
- Assert i_rst during WRITE of an SB:
  - No memory write occurs.
  - The FSM is in IDLE with all outputs at reset values next cycle.
  - No response is emitted.
